// File: rtl/pl_preload_ctl.sv
// Preload bus initiator for the TDP18K RAM chain: streams words into one RAM (or all of them
// via PL_INIT), or reads a RAM back and counts mismatches against the incoming stream.
module pl_preload_ctl #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 18,
    parameter int ID_WIDTH   = 16,
    parameter int RD_LAT     = 1
) (
    input  logic                  PL_CLK,
    input  logic                  PL_RESET_N,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic                  CMD_OP,
    input  logic                  CMD_BCAST,
    input  logic [ID_WIDTH-1:0]   CMD_RAM_ID,
    input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
    input  logic [ADDR_WIDTH-1:0] CMD_LEN,
    input  logic                  DIN_VALID,
    output logic                  DIN_READY,
    input  logic [DATA_WIDTH-1:0] DIN_DATA,
    output logic                  PL_INIT,
    output logic                  PL_ENA,
    output logic                  PL_WEN,
    output logic                  PL_REN,
    output logic [31:0]           PL_ADDR,
    output logic [DATA_WIDTH-1:0] PL_DATA_IN,
    input  logic [DATA_WIDTH-1:0] PL_DATA_OUT,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERR,
    output logic [11:0]           ERR_CNT,
    output logic [ADDR_WIDTH-1:0] ERR_ADDR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_VERIFY,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH:0]   REM_ONE    = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);
    localparam logic [1:0]            DRAIN_LAST = 2'(RD_LAT);

    state_t                r_state;
    logic                  r_cmd_ready;
    logic                  r_din_ready;
    logic                  r_init;
    logic                  r_ena;
    logic                  r_wen;
    logic                  r_ren;
    logic [31:0]           r_pl_addr;
    logic [DATA_WIDTH-1:0] r_data_in;
    logic                  r_busy;
    logic                  r_done;
    logic [ID_WIDTH-1:0]   r_ram_id;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_remaining;
    logic [1:0]            r_drain_cnt;

    logic                  r_err;
    logic [11:0]           r_err_cnt;
    logic [ADDR_WIDTH-1:0] r_err_addr;

    logic                  r_pipe_vld  [0:RD_LAT];
    logic [DATA_WIDTH-1:0] r_pipe_data [0:RD_LAT];
    logic [ADDR_WIDTH-1:0] r_pipe_addr [0:RD_LAT];

    logic                  w_accept;
    logic                  w_fire;
    logic                  w_mismatch;
    logic [31:0]           w_pl_addr_next;

    assign w_accept   = r_cmd_ready & CMD_VALID;
    assign w_fire     = r_din_ready & DIN_VALID;
    assign w_mismatch = r_pipe_vld[RD_LAT] && (PL_DATA_OUT != r_pipe_data[RD_LAT]);

    // Bus address layout: RAM id in the top bits, zero padding, word address at the bottom.
    always_comb begin
        w_pl_addr_next                   = '0;
        w_pl_addr_next[ADDR_WIDTH-1:0]   = r_addr;
        w_pl_addr_next[31 -: ID_WIDTH]   = r_ram_id;
    end

    always_ff @(posedge PL_CLK or negedge PL_RESET_N) begin
        if (!PL_RESET_N) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
            r_din_ready <= 1'b0;
            r_init      <= 1'b0;
            r_ena       <= 1'b0;
            r_wen       <= 1'b0;
            r_ren       <= 1'b0;
            r_pl_addr   <= '0;
            r_data_in   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ram_id    <= '0;
            r_addr      <= '0;
            r_remaining <= '0;
            r_drain_cnt <= '0;
        end else begin
            r_wen  <= 1'b0;
            r_ren  <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (w_accept) begin
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_ena       <= 1'b1;
                        r_init      <= ~CMD_OP & CMD_BCAST;
                        r_ram_id    <= CMD_RAM_ID;
                        r_addr      <= CMD_ADDR;
                        r_remaining <= {1'b0, CMD_LEN} + REM_ONE;
                        r_din_ready <= 1'b1;
                        if (CMD_OP) begin
                            r_state   <= S_VERIFY;
                            r_data_in <= '0;
                        end else begin
                            r_state   <= S_WRITE;
                        end
                    end
                end
                // The state is held one extra cycle after the last handshake so the final
                // bus beat is still issued inside WRITE/VERIFY.
                S_WRITE, S_VERIFY: begin
                    if (w_fire) begin
                        r_pl_addr   <= w_pl_addr_next;
                        r_addr      <= r_addr + ADDR_ONE;
                        r_remaining <= r_remaining - REM_ONE;
                        if (r_remaining == REM_ONE) begin
                            r_din_ready <= 1'b0;
                        end
                        if (r_state == S_WRITE) begin
                            r_wen     <= 1'b1;
                            r_data_in <= DIN_DATA;
                        end else begin
                            r_ren     <= 1'b1;
                        end
                    end else if (!r_din_ready) begin
                        if (r_state == S_WRITE) begin
                            r_state <= S_DONE;
                            r_ena   <= 1'b0;
                            r_init  <= 1'b0;
                        end else begin
                            r_state     <= S_DRAIN;
                            r_drain_cnt <= '0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_drain_cnt == DRAIN_LAST) begin
                        r_state <= S_DONE;
                        r_ena   <= 1'b0;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 2'd1;
                    end
                end
                S_DONE: begin
                    r_done      <= 1'b1;
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Expected word and its address travel alongside the RAM read latency.
    always_ff @(posedge PL_CLK or negedge PL_RESET_N) begin
        if (!PL_RESET_N) begin
            for (int k = 0; k <= RD_LAT; k++) begin
                r_pipe_vld[k]  <= 1'b0;
                r_pipe_data[k] <= '0;
                r_pipe_addr[k] <= '0;
            end
        end else begin
            r_pipe_vld[0]  <= w_fire && (r_state == S_VERIFY);
            r_pipe_data[0] <= DIN_DATA;
            r_pipe_addr[0] <= r_addr;
            for (int k = 1; k <= RD_LAT; k++) begin
                r_pipe_vld[k]  <= r_pipe_vld[k-1];
                r_pipe_data[k] <= r_pipe_data[k-1];
                r_pipe_addr[k] <= r_pipe_addr[k-1];
            end
        end
    end

    always_ff @(posedge PL_CLK or negedge PL_RESET_N) begin
        if (!PL_RESET_N) begin
            r_err      <= 1'b0;
            r_err_cnt  <= '0;
            r_err_addr <= '0;
        end else if (w_accept) begin
            r_err      <= 1'b0;
            r_err_cnt  <= '0;
            r_err_addr <= '0;
        end else if (w_mismatch) begin
            r_err <= 1'b1;
            if (r_err_cnt != 12'hFFF) begin
                r_err_cnt <= r_err_cnt + 12'd1;
            end
            if (r_err_cnt == 12'd0) begin
                r_err_addr <= r_pipe_addr[RD_LAT];
            end
        end
    end

    assign CMD_READY  = r_cmd_ready;
    assign DIN_READY  = r_din_ready;
    assign PL_INIT    = r_init;
    assign PL_ENA     = r_ena;
    assign PL_WEN     = r_wen;
    assign PL_REN     = r_ren;
    assign PL_ADDR    = r_pl_addr;
    assign PL_DATA_IN = r_data_in;
    assign BUSY       = r_busy;
    assign DONE       = r_done;
    assign ERR        = r_err;
    assign ERR_CNT    = r_err_cnt;
    assign ERR_ADDR   = r_err_addr;

endmodule

// File: tb/tb_pl_preload_ctl.sv
// Bench for pl_preload_ctl: a RAM model answers the preload bus, a monitor logs bus beats,
// and each test task compares the logged beats and status against its own expectations.
module tb_pl_preload_ctl;

    localparam int AW     = 11;
    localparam int DW     = 18;
    localparam int IW     = 16;
    localparam int RD_LAT = 2;

    typedef logic [32+DW-1:0] wr_t;

    logic          PL_CLK = 1'b0;
    logic          PL_RESET_N;
    logic          CMD_VALID, CMD_READY, CMD_OP, CMD_BCAST;
    logic [IW-1:0] CMD_RAM_ID;
    logic [AW-1:0] CMD_ADDR, CMD_LEN;
    logic          DIN_VALID, DIN_READY;
    logic [DW-1:0] DIN_DATA;
    logic          PL_INIT, PL_ENA, PL_WEN, PL_REN;
    logic [31:0]   PL_ADDR;
    logic [DW-1:0] PL_DATA_IN, PL_DATA_OUT;
    logic          BUSY, DONE, ERR;
    logic [11:0]   ERR_CNT;
    logic [AW-1:0] ERR_ADDR;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [DW-1:0] stim [$];
    wr_t           expWr [$];
    wr_t           obsWr [$];
    logic [31:0]   expRd [$];
    logic [31:0]   obsRd [$];
    int cntEna, cntInit, cntWen, cntRen, cntDone, doneCyc, hiBad, dinNz;

    logic [DW-1:0] mem [0:2047];
    logic [DW-1:0] rdPipe [0:RD_LAT-1];

    pl_preload_ctl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .RD_LAT(RD_LAT)
    ) dut (
        .PL_CLK(PL_CLK), .PL_RESET_N(PL_RESET_N),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP), .CMD_BCAST(CMD_BCAST),
        .CMD_RAM_ID(CMD_RAM_ID), .CMD_ADDR(CMD_ADDR), .CMD_LEN(CMD_LEN),
        .DIN_VALID(DIN_VALID), .DIN_READY(DIN_READY), .DIN_DATA(DIN_DATA),
        .PL_INIT(PL_INIT), .PL_ENA(PL_ENA), .PL_WEN(PL_WEN), .PL_REN(PL_REN),
        .PL_ADDR(PL_ADDR), .PL_DATA_IN(PL_DATA_IN), .PL_DATA_OUT(PL_DATA_OUT),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .ERR_CNT(ERR_CNT), .ERR_ADDR(ERR_ADDR)
    );

    always #5 PL_CLK = ~PL_CLK;

    always @(posedge PL_CLK) cyc <= cyc + 1;

    // RAM chain model: synchronous write, read data appears RD_LAT cycles after PL_REN.
    always @(posedge PL_CLK) begin
        if (PL_WEN) mem[PL_ADDR[10:0]] <= PL_DATA_IN;
        rdPipe[0] <= mem[PL_ADDR[10:0]];
        for (int k = 1; k < RD_LAT; k++) rdPipe[k] <= rdPipe[k-1];
    end
    assign PL_DATA_OUT = rdPipe[RD_LAT-1];

    // Bus monitor: only records what the DUT drives, the tests judge it.
    always @(negedge PL_CLK) begin
        if (PL_ENA)  cntEna++;
        if (PL_INIT) cntInit++;
        if (PL_WEN) begin
            cntWen++;
            obsWr.push_back({PL_ADDR, PL_DATA_IN});
        end
        if (PL_REN) begin
            cntRen++;
            obsRd.push_back(PL_ADDR);
            if (PL_DATA_IN != '0) dinNz++;
        end
        if (PL_ADDR[15:11] != 5'd0) hiBad++;
        if (DONE) begin
            cntDone++;
            doneCyc = cyc;
        end
    end

    function automatic logic [81:0] allOutputs();
        return {CMD_READY, DIN_READY, PL_INIT, PL_ENA, PL_WEN, PL_REN, PL_ADDR, PL_DATA_IN,
                BUSY, DONE, ERR, ERR_CNT, ERR_ADDR};
    endfunction

    task automatic clearLogs();
        expWr.delete(); obsWr.delete(); expRd.delete(); obsRd.delete();
        cntEna = 0; cntInit = 0; cntWen = 0; cntRen = 0; cntDone = 0;
        doneCyc = -1; hiBad = 0; dinNz = 0;
    endtask

    // Issues one command, streams stim[] into it and waits for DONE.
    task automatic do_cmd(input logic op, input logic bcast, input logic [IW-1:0] id,
                          input logic [AW-1:0] addr, input logic [AW-1:0] len,
                          input logic stall, output int acc, output logic timedOut);
        int nWords, i, n, budget;
        logic [AW-1:0] a;
        nWords = int'(len) + 1;
        timedOut = 1'b0; acc = 0; a = addr; i = 0; n = 0; budget = 0;
        @(negedge PL_CLK);
        CMD_VALID = 1'b1; CMD_OP = op; CMD_BCAST = bcast;
        CMD_RAM_ID = id; CMD_ADDR = addr; CMD_LEN = len;
        while (!CMD_READY && budget < 20) begin
            @(negedge PL_CLK);
            budget++;
        end
        if (!CMD_READY) begin
            CMD_VALID = 1'b0;
            timedOut = 1'b1;
            return;
        end
        acc = cyc;
        @(posedge PL_CLK);
        #1;
        CMD_VALID = 1'b0;
        clearLogs();
        while (i < nWords && n < 4000) begin
            @(negedge PL_CLK);
            n++;
            DIN_VALID = stall ? (n % 2 == 1) : 1'b1;
            DIN_DATA  = stim[i];
            if (DIN_VALID && DIN_READY) begin
                if (op) expRd.push_back({id, 5'b0, a});
                else    expWr.push_back({id, 5'b0, a, stim[i]});
                i++;
                a = a + 11'd1;
            end
        end
        @(negedge PL_CLK);
        DIN_VALID = 1'b0;
        if (i < nWords) timedOut = 1'b1;
        budget = 0;
        while (cntDone == 0 && budget < 200) begin
            @(negedge PL_CLK);
            #1;
            budget++;
        end
        if (cntDone == 0) timedOut = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (allOutputs() !== '0) begin
            bad++;
            $display("[TB] FAIL reset_outputs got=%h exp=0", allOutputs());
        end
        @(negedge PL_CLK);
        PL_RESET_N = 1'b1;
        @(negedge PL_CLK);
        total++;
        if (CMD_READY !== 1'b1 || BUSY !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_idle got ready=%b busy=%b exp ready=1 busy=0", CMD_READY, BUSY);
        end
    endtask

    task automatic test_write();
        int acc; logic to; wr_t e, o;
        stim = '{18'h3FFFF, 18'h00001, 18'h2AAAA, 18'h15555};
        do_cmd(1'b0, 1'b0, 16'h0003, 11'h010, 11'd3, 1'b0, acc, to);
        total++;
        if (to) begin bad++; $display("[TB] FAIL write_timeout got=timeout exp=done"); end
        while (expWr.size() > 0) begin
            e = expWr.pop_front();
            total++;
            if (obsWr.size() == 0) begin
                bad++; $display("[TB] FAIL write_beat got=none exp=%h", e);
            end else begin
                o = obsWr.pop_front();
                if (o !== e) begin bad++; $display("[TB] FAIL write_beat got=%h exp=%h", o, e); end
            end
        end
        total++;
        if (cntWen !== 4) begin bad++; $display("[TB] FAIL write_wen_count got=%0d exp=4", cntWen); end
        total++;
        if (doneCyc !== acc + 7) begin bad++; $display("[TB] FAIL write_done_cycle got=%0d exp=%0d", doneCyc - acc, 7); end
        total++;
        if (cntEna !== 5 || cntInit !== 0) begin
            bad++; $display("[TB] FAIL write_ena_init got ena=%0d init=%0d exp ena=5 init=0", cntEna, cntInit);
        end
        total++;
        if (hiBad !== 0) begin bad++; $display("[TB] FAIL write_addr_pad got=%0d exp=0", hiBad); end
        total++;
        if (BUSY !== 1'b0 || ERR !== 1'b0) begin
            bad++; $display("[TB] FAIL write_status got busy=%b err=%b exp 0 0", BUSY, ERR);
        end
    endtask

    task automatic test_verify_clean();
        int acc; logic to; logic [31:0] e, o;
        stim = '{18'h3FFFF, 18'h00001, 18'h2AAAA, 18'h15555};
        do_cmd(1'b1, 1'b0, 16'h0003, 11'h010, 11'd3, 1'b0, acc, to);
        total++;
        if (to) begin bad++; $display("[TB] FAIL verify_timeout got=timeout exp=done"); end
        while (expRd.size() > 0) begin
            e = expRd.pop_front();
            total++;
            if (obsRd.size() == 0) begin
                bad++; $display("[TB] FAIL verify_read got=none exp=%h", e);
            end else begin
                o = obsRd.pop_front();
                if (o !== e) begin bad++; $display("[TB] FAIL verify_read got=%h exp=%h", o, e); end
            end
        end
        total++;
        if (cntRen !== 4 || cntWen !== 0 || dinNz !== 0) begin
            bad++; $display("[TB] FAIL verify_bus got ren=%0d wen=%0d dinnz=%0d exp 4 0 0", cntRen, cntWen, dinNz);
        end
        total++;
        if (doneCyc !== acc + 8 + RD_LAT) begin
            bad++; $display("[TB] FAIL verify_done_cycle got=%0d exp=%0d", doneCyc - acc, 8 + RD_LAT);
        end
        total++;
        if (ERR !== 1'b0 || ERR_CNT !== 12'd0) begin
            bad++; $display("[TB] FAIL verify_clean_err got err=%b cnt=%0d exp 0 0", ERR, ERR_CNT);
        end
    endtask

    task automatic test_verify_corrupt();
        int acc; logic to;
        stim = '{18'h3FFFF, 18'h00001 ^ 18'h00100, 18'h2AAAA, 18'h15555 ^ 18'h3FFFF};
        do_cmd(1'b1, 1'b0, 16'h0003, 11'h010, 11'd3, 1'b0, acc, to);
        total++;
        if (to) begin bad++; $display("[TB] FAIL corrupt_timeout got=timeout exp=done"); end
        total++;
        if (ERR !== 1'b1 || ERR_CNT !== 12'd2 || ERR_ADDR !== 11'h011) begin
            bad++;
            $display("[TB] FAIL corrupt_err got err=%b cnt=%0d addr=%h exp err=1 cnt=2 addr=011", ERR, ERR_CNT, ERR_ADDR);
        end
        repeat (2) @(negedge PL_CLK);
        total++;
        if (ERR !== 1'b1 || ERR_CNT !== 12'd2) begin
            bad++; $display("[TB] FAIL corrupt_hold got err=%b cnt=%0d exp err=1 cnt=2", ERR, ERR_CNT);
        end
    endtask

    task automatic test_wrap_stall();
        int acc; logic to; wr_t e, o;
        stim = '{18'h12345, 18'h0ABCD, 18'h3C3C3, 18'h00F0F};
        do_cmd(1'b0, 1'b0, 16'h0009, 11'h7FE, 11'd3, 1'b1, acc, to);
        total++;
        if (to) begin bad++; $display("[TB] FAIL wrap_timeout got=timeout exp=done"); end
        while (expWr.size() > 0) begin
            e = expWr.pop_front();
            total++;
            if (obsWr.size() == 0) begin
                bad++; $display("[TB] FAIL wrap_beat got=none exp=%h", e);
            end else begin
                o = obsWr.pop_front();
                if (o !== e) begin bad++; $display("[TB] FAIL wrap_beat got=%h exp=%h", o, e); end
            end
        end
        total++;
        if (cntWen !== 4) begin bad++; $display("[TB] FAIL wrap_wen_count got=%0d exp=4", cntWen); end
        total++;
        if (cntEna !== doneCyc - acc - 2 || cntEna <= cntWen) begin
            bad++; $display("[TB] FAIL wrap_ena_continuous got=%0d exp=%0d", cntEna, doneCyc - acc - 2);
        end
        total++;
        if (ERR !== 1'b0 || ERR_CNT !== 12'd0 || ERR_ADDR !== 11'd0) begin
            bad++; $display("[TB] FAIL wrap_err_cleared got err=%b cnt=%0d addr=%h exp 0", ERR, ERR_CNT, ERR_ADDR);
        end
    endtask

    task automatic test_bcast();
        int acc; logic to;
        stim = '{18'h11111, 18'h22222, 18'h33333};
        do_cmd(1'b0, 1'b1, 16'h0005, 11'h100, 11'd2, 1'b0, acc, to);
        total++;
        if (to) begin bad++; $display("[TB] FAIL bcast_wr_timeout got=timeout exp=done"); end
        total++;
        if (cntInit !== 4 || cntEna !== 4) begin
            bad++; $display("[TB] FAIL bcast_init_write got init=%0d ena=%0d exp 4 4", cntInit, cntEna);
        end
        do_cmd(1'b1, 1'b1, 16'h0005, 11'h100, 11'd2, 1'b0, acc, to);
        total++;
        if (to) begin bad++; $display("[TB] FAIL bcast_vf_timeout got=timeout exp=done"); end
        total++;
        if (cntInit !== 0 || cntRen !== 3 || ERR !== 1'b0) begin
            bad++; $display("[TB] FAIL bcast_init_verify got init=%0d ren=%0d err=%b exp 0 3 0", cntInit, cntRen, ERR);
        end
    endtask

    task automatic test_reset_midcmd();
        int acc, budget; logic to; wr_t e;
        stim = '{18'h0AAAA, 18'h15555, 18'h00007, 18'h00008};
        @(negedge PL_CLK);
        CMD_VALID = 1'b1; CMD_OP = 1'b0; CMD_BCAST = 1'b1;
        CMD_RAM_ID = 16'h0007; CMD_ADDR = 11'h200; CMD_LEN = 11'd3;
        budget = 0;
        while (!CMD_READY && budget < 20) begin @(negedge PL_CLK); budget++; end
        @(posedge PL_CLK);
        #1;
        CMD_VALID = 1'b0;
        clearLogs();
        @(negedge PL_CLK);
        DIN_VALID = 1'b1; DIN_DATA = stim[0];
        @(negedge PL_CLK);
        DIN_DATA = stim[1];
        total++;
        if (BUSY !== 1'b1 || PL_WEN !== 1'b1) begin
            bad++; $display("[TB] FAIL midcmd_active got busy=%b wen=%b exp 1 1", BUSY, PL_WEN);
        end
        #2;
        PL_RESET_N = 1'b0;
        #1;
        total++;
        if (allOutputs() !== '0) begin
            bad++; $display("[TB] FAIL midcmd_reset_outputs got=%h exp=0", allOutputs());
        end
        DIN_VALID = 1'b0;
        repeat (3) @(negedge PL_CLK);
        PL_RESET_N = 1'b1;
        repeat (5) @(negedge PL_CLK);
        #1;
        total++;
        if (cntDone !== 0) begin bad++; $display("[TB] FAIL midcmd_no_done got=%0d exp=0", cntDone); end
        total++;
        if (CMD_READY !== 1'b1 || BUSY !== 1'b0) begin
            bad++; $display("[TB] FAIL midcmd_ready got ready=%b busy=%b exp 1 0", CMD_READY, BUSY);
        end
        stim = '{18'h01234, 18'h04321};
        do_cmd(1'b0, 1'b0, 16'h0007, 11'h210, 11'd1, 1'b0, acc, to);
        total++;
        if (to || doneCyc !== acc + 5) begin
            bad++; $display("[TB] FAIL midcmd_recover got to=%b done=%0d exp to=0 done=5", to, doneCyc - acc);
        end
        e = {16'h0007, 5'b0, 11'h210, 18'h01234};
        total++;
        if (obsWr.size() != 2 || obsWr[0] !== e) begin
            bad++; $display("[TB] FAIL midcmd_recover_beat got n=%0d exp n=2 first=%h", obsWr.size(), e);
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog got=stuck exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int k = 0; k < 2048; k++) mem[k] = '0;
        for (int k = 0; k < RD_LAT; k++) rdPipe[k] = '0;
        PL_RESET_N = 1'b0;
        CMD_VALID = 1'b0; CMD_OP = 1'b0; CMD_BCAST = 1'b0;
        CMD_RAM_ID = '0; CMD_ADDR = '0; CMD_LEN = '0;
        DIN_VALID = 1'b0; DIN_DATA = '0;
        clearLogs();
        repeat (2) @(negedge PL_CLK);
        test_reset();
        test_write();
        test_verify_clean();
        test_verify_corrupt();
        test_wrap_stall();
        test_bcast();
        test_reset_midcmd();
        repeat (2) @(negedge PL_CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
